// File: rtl/comp_pkg.sv
// Shared types and defaults for the chunk-serial magnitude comparator.
package comp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COMPARE = 1'b1
  } state_e;

  function automatic int idx_width(input int nchunk);
    idx_width = (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_comp.sv
// Combinational compare of one CHUNK-bit slice.
module chunk_comp
  import comp_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: walks operands one chunk per cycle,
// MSB chunk first, and stops at the first differing chunk.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;

  logic [CHUNK-1:0] a_chunks_s [NCHUNK];
  logic [CHUNK-1:0] b_chunks_s [NCHUNK];
  logic             c_lt_s;
  logic             c_gt_s;
  logic             c_eq_s;

  // Chunk 0 is the most significant slice of each operand.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
    assign a_chunks_s[g] = a_q[WIDTH-1-g*CHUNK -: CHUNK];
    assign b_chunks_s[g] = b_q[WIDTH-1-g*CHUNK -: CHUNK];
  end

  chunk_comp #(
    .CHUNK (CHUNK)
  ) u_chunk_comp (
    .a_i  (a_chunks_s[idx_q]),
    .b_i  (b_chunks_s[idx_q]),
    .lt_o (c_lt_s),
    .gt_o (c_gt_s),
    .eq_o (c_eq_s)
  );

  // Flipping both sign bits at capture turns a signed compare into an unsigned one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a ^ (signed_mode ? MSB_MASK : '0);
            b_q     <= b ^ (signed_mode ? MSB_MASK : '0);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_COMPARE;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (!c_eq_s) begin
            lt_q    <= c_lt_s;
            gt_q    <= c_gt_s;
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end else if (idx_q == LAST_IDX) begin
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule
